// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: control codes, opcodes, functs.
// Used by the ID/EX operand stage and the ALU itself.
package mips_alu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_XOR = 3'd2,
      ALU_SLT = 3'd3,
      ALU_AND = 3'd4,
      ALU_ERR = 3'd5,
      ALU_NOR = 3'd6,
      ALU_OR  = 3'd7
   } alu_ctl_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mips_alu_decode.sv
// Opcode/funct to ALU control, operand-b source and
// immediate extension kind. Purely combinational.
module mips_alu_decode
   import mips_alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctl,
   output logic       use_imm,
   output logic       zext,
   output logic       uses_rt
);

   always_comb begin
      alu_ctl = ALU_ERR;
      use_imm = 1'b1;
      zext    = 1'b0;
      uses_rt = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            use_imm = 1'b0;
            uses_rt = 1'b1;
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_XOR:  alu_ctl = ALU_XOR;
               FN_NOR:  alu_ctl = ALU_NOR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: alu_ctl = ALU_ERR;
            endcase
         end
         OP_ADDI: alu_ctl = ALU_ADD;
         OP_SLTI: alu_ctl = ALU_SLT;
         OP_ANDI: begin
            alu_ctl = ALU_AND;
            zext    = 1'b1;
         end
         OP_ORI: begin
            alu_ctl = ALU_OR;
            zext    = 1'b1;
         end
         OP_XORI: begin
            alu_ctl = ALU_XOR;
            zext    = 1'b1;
         end
         OP_LW: alu_ctl = ALU_ADD;
         OP_SW: begin
            alu_ctl = ALU_ADD;
            uses_rt = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            alu_ctl = ALU_SUB;
            use_imm = 1'b0;
            uses_rt = 1'b1;
         end
         default: alu_ctl = ALU_ERR;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX stage: operand forwarding, immediate extension,
// load-use hazard detection and the ALU input register.
module id_ex_operand_stage
   import mips_alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd_dest,
   input  logic [XLEN-1:0]   in_rs_val,
   input  logic [XLEN-1:0]   in_rt_val,
   input  logic [15:0]       in_imm16,
   input  logic              in_mem_read,
   input  logic              flush,
   input  logic [XLEN-1:0]   ex_fwd_val,
   input  logic [XLEN-1:0]   mem_fwd_val,
   input  logic [REG_AW-1:0] mem_fwd_dest,
   input  logic              mem_fwd_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic              alu_cin,
   output logic [2:0]        alu_ctl,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_mem_read,
   output logic [XLEN-1:0]   out_store_val,
   output logic              illegal
);

   logic [2:0]      dec_ctl;
   logic            use_imm;
   logic            zext;
   logic            uses_rt;
   logic [XLEN-1:0] rs_op;
   logic [XLEN-1:0] rt_op;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] b_op;
   logic            ex_ok;
   logic            advance;
   logic            hazard;
   logic            load;

   mips_alu_decode u_dec (
      .opcode  (in_opcode),
      .funct   (in_funct),
      .alu_ctl (dec_ctl),
      .use_imm (use_imm),
      .zext    (zext),
      .uses_rt (uses_rt)
   );

   // A load in EX has no result yet, so it never forwards.
   assign ex_ok = out_valid & ~out_mem_read;

   always_comb begin
      if (in_rs == '0)
         rs_op = '0;
      else if (ex_ok && out_dest == in_rs)
         rs_op = ex_fwd_val;
      else if (mem_fwd_we && mem_fwd_dest == in_rs)
         rs_op = mem_fwd_val;
      else
         rs_op = in_rs_val;
   end

   always_comb begin
      if (in_rt == '0)
         rt_op = '0;
      else if (ex_ok && out_dest == in_rt)
         rt_op = ex_fwd_val;
      else if (mem_fwd_we && mem_fwd_dest == in_rt)
         rt_op = mem_fwd_val;
      else
         rt_op = in_rt_val;
   end

   assign imm_ext = zext ? {{(XLEN-16){1'b0}}, in_imm16}
                         : {{(XLEN-16){in_imm16[15]}}, in_imm16};
   assign b_op    = use_imm ? imm_ext : rt_op;

   assign advance = out_ready | ~out_valid;
   assign hazard  = out_valid & out_mem_read
                  & (out_dest != '0) & in_valid
                  & ((in_rs == out_dest)
                     | (uses_rt & (in_rt == out_dest)));
   assign in_ready = flush | (advance & ~hazard);
   assign load     = advance & in_valid & ~hazard;
   assign alu_cin  = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_ctl       <= ALU_ADD;
         out_dest      <= '0;
         out_mem_read  <= 1'b0;
         out_store_val <= '0;
         illegal       <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end else if (load) begin
         out_valid     <= 1'b1;
         alu_a         <= rs_op;
         alu_b         <= b_op;
         alu_ctl       <= dec_ctl;
         out_dest      <= in_rd_dest;
         out_mem_read  <= in_mem_read;
         out_store_val <= rt_op;
         illegal       <= (dec_ctl == ALU_ERR);
      end else if (advance) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus random checks of id_ex_operand_stage
// against a transaction-level model of the stage.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_opcode;
   logic [5:0]  in_funct;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd_dest;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic [15:0] in_imm16;
   logic        in_mem_read;
   logic        flush;
   logic [31:0] ex_fwd_val;
   logic [31:0] mem_fwd_val;
   logic [4:0]  mem_fwd_dest;
   logic        mem_fwd_we;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_cin;
   logic [2:0]  alu_ctl;
   logic [4:0]  out_dest;
   logic        out_mem_read;
   logic [31:0] out_store_val;
   logic        illegal;

   int tests = 0;
   int fails = 0;

   // model of the instruction currently presented to the ALU
   bit          m_init = 0;
   bit          m_rst  = 0;
   logic        m_valid, m_mr, m_ill;
   logic [31:0] m_a, m_b, m_sv;
   logic [2:0]  m_ctl;
   logic [4:0]  m_dest;

   always #5 clk = ~clk;

   id_ex_operand_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_funct      (in_funct),
      .in_rs         (in_rs),
      .in_rt         (in_rt),
      .in_rd_dest    (in_rd_dest),
      .in_rs_val     (in_rs_val),
      .in_rt_val     (in_rt_val),
      .in_imm16      (in_imm16),
      .in_mem_read   (in_mem_read),
      .flush         (flush),
      .ex_fwd_val    (ex_fwd_val),
      .mem_fwd_val   (mem_fwd_val),
      .mem_fwd_dest  (mem_fwd_dest),
      .mem_fwd_we    (mem_fwd_we),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_cin       (alu_cin),
      .alu_ctl       (alu_ctl),
      .out_dest      (out_dest),
      .out_mem_read  (out_mem_read),
      .out_store_val (out_store_val),
      .illegal       (illegal)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   // instruction semantics: ctl, immediate?, zero-extend?, reads rt?
   function automatic void ref_dec(
      input logic [5:0] op, input logic [5:0] fn,
      output int ctl, output bit imm,
      output bit zx, output bit urt);
      ctl = 5; imm = 1; zx = 0; urt = 0;
      if (op == 6'h00) begin
         imm = 0; urt = 1;
         if      (fn == 6'h20) ctl = 0;
         else if (fn == 6'h22) ctl = 1;
         else if (fn == 6'h24) ctl = 4;
         else if (fn == 6'h25) ctl = 7;
         else if (fn == 6'h26) ctl = 2;
         else if (fn == 6'h27) ctl = 6;
         else if (fn == 6'h2A) ctl = 3;
      end
      else if (op == 6'h08 || op == 6'h23) ctl = 0;
      else if (op == 6'h2B) begin ctl = 0; urt = 1; end
      else if (op == 6'h0A) ctl = 3;
      else if (op == 6'h0C) begin ctl = 4; zx = 1; end
      else if (op == 6'h0D) begin ctl = 7; zx = 1; end
      else if (op == 6'h0E) begin ctl = 2; zx = 1; end
      else if (op == 6'h04 || op == 6'h05) begin
         ctl = 1; imm = 0; urt = 1;
      end
   endfunction

   function automatic logic [31:0] src(input logic [4:0] s,
                                       input logic [31:0] rf);
      if (s == 0) return 32'h0;
      if (m_valid && !m_mr && m_dest == s) return ex_fwd_val;
      if (mem_fwd_we && mem_fwd_dest == s) return mem_fwd_val;
      return rf;
   endfunction

   task automatic cyc();
      int ctl;
      bit imm, zx, urt, haz, adv;
      logic [31:0] a, b, rtv;
      ref_dec(in_opcode, in_funct, ctl, imm, zx, urt);
      #1;
      adv = !m_valid || out_ready;
      haz = m_valid && m_mr && m_dest != 0 && in_valid &&
            (in_rs == m_dest || (urt && in_rt == m_dest));
      if (m_init && rst_n)
         chk("in_ready", {31'h0, in_ready},
             {31'h0, flush || (adv && !haz)});
      a   = src(in_rs, in_rs_val);
      rtv = src(in_rt, in_rt_val);
      if (!imm)    b = rtv;
      else if (zx) b = 32'(in_imm16);
      else         b = 32'($signed(in_imm16));
      @(posedge clk);
      m_rst = 0;
      if (!rst_n) begin
         m_valid = 0; m_a = 0; m_b = 0; m_ctl = 0; m_dest = 0;
         m_mr = 0; m_sv = 0; m_ill = 0; m_init = 1; m_rst = 1;
      end else if (flush) begin
         m_valid = 0; m_ill = 0;
      end else if (adv) begin
         if (in_valid && !haz) begin
            m_valid = 1; m_a = a; m_b = b; m_ctl = 3'(ctl);
            m_dest = in_rd_dest; m_mr = in_mem_read;
            m_sv = rtv; m_ill = (ctl == 5);
         end else begin
            m_valid = 0; m_ill = 0;
         end
      end
      #1;
      if (m_init) begin
         chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
         chk("illegal", {31'h0, illegal}, {31'h0, m_ill});
         chk("alu_cin", {31'h0, alu_cin}, 32'h0);
         if (m_valid || m_rst) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_ctl", {29'h0, alu_ctl}, {29'h0, m_ctl});
            chk("out_dest", {27'h0, out_dest}, {27'h0, m_dest});
            chk("mem_read", {31'h0, out_mem_read}, {31'h0, m_mr});
            chk("store_val", out_store_val, m_sv);
         end
      end
      @(negedge clk);
   endtask

   task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsv,
                         input logic [31:0] rtv, input logic [15:0] imm,
                         input logic mr);
      in_valid = 1; in_opcode = op; in_funct = fn;
      in_rs = rs; in_rt = rt; in_rd_dest = rd;
      in_rs_val = rsv; in_rt_val = rtv; in_imm16 = imm;
      in_mem_read = mr;
   endtask

   logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A,
                            6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                            6'h04, 6'h3F};
   logic [5:0] fns [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                            6'h27, 6'h2A, 6'h18};

   initial begin
      rst_n = 0; flush = 0; out_ready = 1;
      ex_fwd_val = 0; mem_fwd_val = 0;
      mem_fwd_dest = 0; mem_fwd_we = 0;
      set_in(6'h00, 6'h20, 1, 2, 3, 5, 7, 0, 0);
      cyc(); cyc();
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_ctl", {29'h0, alu_ctl}, 32'h0);
      chk("rst_ill", {31'h0, illegal}, 32'h0);

      rst_n = 1;
      cyc();
      chk("add_a", alu_a, 32'd5);
      chk("add_b", alu_b, 32'd7);
      chk("add_dest", {27'h0, out_dest}, 32'd3);

      set_in(6'h00, 6'h22, 3, 1, 4, 99, 5, 0, 0);
      ex_fwd_val = 12;
      cyc();
      chk("sub_fwd_a", alu_a, 32'd12);
      chk("sub_ctl", {29'h0, alu_ctl}, 32'd1);

      set_in(6'h23, 6'h00, 1, 5, 5, 100, 0, 0, 1);
      cyc();
      chk("lw_a", alu_a, 32'd100);
      set_in(6'h00, 6'h20, 5, 5, 6, 1, 1, 0, 0);
      #1 chk("lu_ready", {31'h0, in_ready}, 32'h0);
      cyc();
      chk("lu_bubble", {31'h0, out_valid}, 32'h0);
      mem_fwd_we = 1; mem_fwd_dest = 5; mem_fwd_val = 32'hAAAA5555;
      #1 chk("lu_ready2", {31'h0, in_ready}, 32'h1);
      cyc();
      chk("lu_a", alu_a, 32'hAAAA5555);
      chk("lu_b", alu_b, 32'hAAAA5555);

      mem_fwd_we = 0;
      set_in(6'h0C, 6'h00, 1, 7, 7, 3, 0, 16'hFFFF, 0);
      cyc();
      chk("andi_b", alu_b, 32'h0000FFFF);
      set_in(6'h08, 6'h00, 1, 7, 7, 3, 0, 16'hFFFF, 0);
      cyc();
      chk("addi_b", alu_b, 32'hFFFFFFFF);
      mem_fwd_we = 1; mem_fwd_dest = 0; mem_fwd_val = 32'hDEAD;
      set_in(6'h08, 6'h00, 0, 8, 8, 77, 0, 16'h0001, 0);
      cyc();
      chk("rs0_a", alu_a, 32'h0);

      mem_fwd_we = 0;
      set_in(6'h0D, 6'h00, 1, 9, 9, 4, 0, 16'h1234, 0);
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         ex_fwd_val = $urandom;
         #1 chk("stall_ready", {31'h0, in_ready}, 32'h0);
         cyc();
         chk("stall_dest", {27'h0, out_dest}, 32'd8);
         chk("stall_b", alu_b, 32'd1);
      end
      out_ready = 1;
      cyc();
      chk("ori_b", alu_b, 32'h1234);

      flush = 1;
      #1 chk("flush_ready", {31'h0, in_ready}, 32'h1);
      cyc();
      chk("flush_valid", {31'h0, out_valid}, 32'h0);
      flush = 0;

      set_in(6'h00, 6'h18, 1, 2, 10, 1, 2, 0, 0);
      cyc();
      chk("err_ctl", {29'h0, alu_ctl}, 32'd5);
      chk("err_ill", {31'h0, illegal}, 32'h1);
      chk("err_valid", {31'h0, out_valid}, 32'h1);

      for (int i = 0; i < 500; i++) begin
         logic [5:0] op;
         op = ops[$urandom_range(11)];
         set_in(op, fns[$urandom_range(7)],
                5'($urandom_range(3)), 5'($urandom_range(3)),
                5'($urandom_range(3)), $urandom, $urandom,
                16'($urandom), op == 6'h23);
         in_valid     = ($urandom_range(9) < 8);
         out_ready    = ($urandom_range(3) != 0);
         flush        = ($urandom_range(19) == 0);
         ex_fwd_val   = $urandom;
         mem_fwd_val  = $urandom;
         mem_fwd_dest = 5'($urandom_range(3));
         mem_fwd_we   = $urandom_range(1) == 1;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
